// File: rtl/fwd_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard_pkg
// Shared definitions for the forwarding/hazard scoreboard:
//   - RV32I major opcode constants
//   - writeback kind enumeration (write_back_mux_selector)
//   - forwarding select encodings for the classic 3-deep pipeline
//   - fwd_slot_t: per-slot writeback tag (valid + writeback kind)
//   - use_mask_t and decode_use_mask(): which register sources an opcode reads
// -----------------------------------------------------------------------------
package fwd_scoreboard_pkg;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        NO_WRITEBACK = 2'd0,
        ALU_RESULT   = 2'd1,
        MEM          = 2'd2,
        PC_PLUS_4    = 2'd3
    } write_back_mux_selector;

    // Select value k means "take the result held in slot k"; 0 is the register file.
    localparam int ORIGINAL_SELECT   = 0;
    localparam int EX_RESULT_SELECT  = 1;
    localparam int MEM_RESULT_SELECT = 2;

    // Register indices are kept beside this tag because their width is a
    // per-instance parameter.
    typedef struct packed {
        logic                   valid;
        write_back_mux_selector wb_mux;
    } fwd_slot_t;

    typedef struct packed {
        logic rs2;
        logic rs1;
    } use_mask_t;

    function automatic use_mask_t decode_use_mask(input logic [6:0] opcode);
        use_mask_t m;
        m = '{rs2: 1'b0, rs1: 1'b0};
        case (opcode)
            OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: m = '{rs2: 1'b1, rs1: 1'b1};
            OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: m = '{rs2: 1'b0, rs1: 1'b1};
            default:                                m = '{rs2: 1'b0, rs1: 1'b0};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_src_select.sv
// -----------------------------------------------------------------------------
// fwd_src_select
// Priority match of one EX source register against the writers in slots
// 1..DEPTH-1. The lowest matching slot (the youngest writer) wins.
// Ports:
//   src_used_i  slot 0 is valid and actually reads this source
//   src_i       source register index
//   writer_i    per-slot writer flag, bit k-1 <-> slot k
//   rd_i        packed destination indices, slot k at [(k-1)*REG_ADDR_W +: REG_ADDR_W]
//   sel_o       0 = register file, k = slot k result
// -----------------------------------------------------------------------------
module fwd_src_select
    import fwd_scoreboard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int REG_ADDR_W = 5,
    parameter int FWD_W      = 2
) (
    input  logic                              src_used_i,
    input  logic [REG_ADDR_W-1:0]             src_i,
    input  logic [DEPTH-1:1]                  writer_i,
    input  logic [(DEPTH-1)*REG_ADDR_W-1:0]   rd_i,
    output logic [FWD_W-1:0]                  sel_o
);

    logic [DEPTH-1:1] match_s;

    // Per-slot hit: writer whose destination equals the source.
    always_comb begin
        match_s = '0;
        for (int k = 1; k < DEPTH; k++) begin
            match_s[k] = writer_i[k] && (rd_i[(k-1)*REG_ADDR_W +: REG_ADDR_W] == src_i);
        end
    end

    // Scan oldest to youngest so the youngest hit overwrites older ones.
    always_comb begin
        sel_o = FWD_W'(ORIGINAL_SELECT);
        for (int k = DEPTH - 1; k >= 1; k--) begin
            sel_o = match_s[k] ? FWD_W'(k) : sel_o;
        end
        sel_o = src_used_i ? sel_o : FWD_W'(ORIGINAL_SELECT);
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
// Forwarding and load-use hazard unit. Tracks DEPTH in-flight writeback
// records (slot 0 = EX, 1 = MEM, 2 = WB, ...) in a shift register.
// Ports:
//   clk, reset                synchronous active-high reset
//   id_valid/opcode/wb_mux/rd/rs1/rs2   instruction currently in ID
//   pipe_freeze               hold everything (including counters)
//   ex_flush                  replace the instruction entering EX by a bubble
//   fa_sel, fb_sel            combinational operand selects for EX
//   load_use_stall            combinational IF/ID hold request
//   stall_cnt, fwd_cnt        saturating performance counters
// -----------------------------------------------------------------------------
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter  int DEPTH      = 3,
    parameter  int REG_ADDR_W = 5,
    parameter  int CNT_W      = 32,
    localparam int FWD_W      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [6:0]             id_opcode,
    input  write_back_mux_selector id_wb_mux,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   pipe_freeze,
    input  logic                   ex_flush,
    output logic [FWD_W-1:0]       fa_sel,
    output logic [FWD_W-1:0]       fb_sel,
    output logic                   load_use_stall,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       fwd_cnt
);

    fwd_slot_t             slot_q [DEPTH];
    fwd_slot_t             slot_d [DEPTH];
    logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
    logic [REG_ADDR_W-1:0] rd_d   [DEPTH];

    // Source information is only ever consulted for the instruction in EX.
    use_mask_t             ex_use_q, ex_use_d;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;

    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      fwd_cnt_q, fwd_cnt_d;

    logic [DEPTH-1:0]                writer_s;
    logic [(DEPTH-1)*REG_ADDR_W-1:0] rd_pack_s;
    use_mask_t                       id_use_s;
    logic                            ld_hit_s;
    logic                            fwd_event_s;

    // Writer flags and packed destinations of the older slots.
    always_comb begin
        writer_s  = '0;
        rd_pack_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            writer_s[k] = slot_q[k].valid && (slot_q[k].wb_mux != NO_WRITEBACK) &&
                          (rd_q[k] != '0);
        end
        for (int k = 1; k < DEPTH; k++) begin
            rd_pack_s[(k-1)*REG_ADDR_W +: REG_ADDR_W] = rd_q[k];
        end
    end

    fwd_src_select #(
        .DEPTH      (DEPTH),
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_W      (FWD_W)
    ) u_sel_a (
        .src_used_i (slot_q[0].valid && ex_use_q.rs1),
        .src_i      (ex_rs1_q),
        .writer_i   (writer_s[DEPTH-1:1]),
        .rd_i       (rd_pack_s),
        .sel_o      (fa_sel)
    );

    fwd_src_select #(
        .DEPTH      (DEPTH),
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_W      (FWD_W)
    ) u_sel_b (
        .src_used_i (slot_q[0].valid && ex_use_q.rs2),
        .src_i      (ex_rs2_q),
        .writer_i   (writer_s[DEPTH-1:1]),
        .rd_i       (rd_pack_s),
        .sel_o      (fb_sel)
    );

    // A load in EX cannot forward to ID's consumer in time; freeze and flush
    // both already keep the consumer out of EX, so they mask the request.
    always_comb begin
        id_use_s = decode_use_mask(id_opcode);
        ld_hit_s = writer_s[0] && (slot_q[0].wb_mux == MEM) &&
                   ((id_use_s.rs1 && (rd_q[0] == id_rs1)) ||
                    (id_use_s.rs2 && (rd_q[0] == id_rs2)));
        load_use_stall = id_valid && ld_hit_s && !pipe_freeze && !ex_flush;
        fwd_event_s    = !pipe_freeze && slot_q[0].valid &&
                         ((fa_sel != '0) || (fb_sel != '0));
    end

    // Slot shift / capture next state.
    always_comb begin
        slot_d   = slot_q;
        rd_d     = rd_q;
        ex_use_d = ex_use_q;
        ex_rs1_d = ex_rs1_q;
        ex_rs2_d = ex_rs2_q;
        if (pipe_freeze) begin
            slot_d   = slot_q;
            rd_d     = rd_q;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                slot_d[k] = slot_q[k-1];
                rd_d[k]   = rd_q[k-1];
            end
            if (ex_flush || load_use_stall) begin
                slot_d[0] = '{valid: 1'b0, wb_mux: NO_WRITEBACK};
                rd_d[0]   = '0;
                ex_use_d  = '{rs2: 1'b0, rs1: 1'b0};
                ex_rs1_d  = '0;
                ex_rs2_d  = '0;
            end else begin
                slot_d[0] = '{valid: id_valid, wb_mux: id_wb_mux};
                rd_d[0]   = id_rd;
                ex_use_d  = id_use_s;
                ex_rs1_d  = id_rs1;
                ex_rs2_d  = id_rs2;
            end
        end
    end

    // Saturating counter next state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (load_use_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (fwd_event_s && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end else begin
            fwd_cnt_d = fwd_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '{valid: 1'b0, wb_mux: NO_WRITEBACK};
                rd_q[k]   <= '0;
            end
            ex_use_q    <= '{rs2: 1'b0, rs1: 1'b0};
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            slot_q      <= slot_d;
            rd_q        <= rd_d;
            ex_use_q    <= ex_use_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_fwd_scoreboard
// Directed bench for fwd_scoreboard (DEPTH = 3, CNT_W = 4). A history-log
// model predicts every output on each falling edge; hand-computed literal
// checks pin the model on the key scenarios.
// -----------------------------------------------------------------------------
module tb_fwd_scoreboard;
    import fwd_scoreboard_pkg::*;

    localparam int DEPTH = 3;
    localparam int RW    = 5;
    localparam int CW    = 4;
    localparam int FW    = $clog2(DEPTH);
    localparam int CMAX  = (1 << CW) - 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   id_valid;
    logic [6:0]             id_opcode;
    write_back_mux_selector id_wb_mux;
    logic [RW-1:0]          id_rd, id_rs1, id_rs2;
    logic                   pipe_freeze, ex_flush;
    logic [FW-1:0]          fa_sel, fb_sel;
    logic                   load_use_stall;
    logic [CW-1:0]          stall_cnt, fwd_cnt;

    int errors = 0;
    int checks = 0;

    fwd_scoreboard #(.DEPTH(DEPTH), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_opcode      (id_opcode),
        .id_wb_mux      (id_wb_mux),
        .id_rd          (id_rd),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .pipe_freeze    (pipe_freeze),
        .ex_flush       (ex_flush),
        .fa_sel         (fa_sel),
        .fb_sel         (fb_sel),
        .load_use_stall (load_use_stall),
        .stall_cnt      (stall_cnt),
        .fwd_cnt        (fwd_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit                     v;
        logic [6:0]             op;
        write_back_mux_selector wb;
        logic [RW-1:0]          rd, rs1, rs2;
    } rec_t;

    rec_t hist[$];          // hist[i] = instruction that entered EX i edges ago
    int   m_stall_cnt = 0;
    int   m_fwd_cnt   = 0;

    function automatic rec_t slot(input int k);
        rec_t r;
        r = '{v: 1'b0, op: 7'd0, wb: NO_WRITEBACK, rd: '0, rs1: '0, rs2: '0};
        if (k < hist.size()) r = hist[k];
        return r;
    endfunction

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH,
                          OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH};
    endfunction

    function automatic bit writes(input rec_t r);
        return r.v && (r.wb != NO_WRITEBACK) && (r.rd != 0);
    endfunction

    function automatic int m_sel(input int which);
        rec_t ex;
        logic [RW-1:0] src;
        bit used;
        ex   = slot(0);
        src  = (which == 0) ? ex.rs1 : ex.rs2;
        used = (which == 0) ? reads_rs1(ex.op) : reads_rs2(ex.op);
        if (!ex.v || !used) return 0;
        for (int k = 1; k < DEPTH; k++) begin
            if (writes(slot(k)) && slot(k).rd == src) return k;
        end
        return 0;
    endfunction

    function automatic bit m_stall();
        rec_t ex;
        ex = slot(0);
        if (!id_valid || pipe_freeze || ex_flush) return 1'b0;
        if (!writes(ex) || ex.wb != MEM) return 1'b0;
        return (reads_rs1(id_opcode) && ex.rd == id_rs1) ||
               (reads_rs2(id_opcode) && ex.rd == id_rs2);
    endfunction

    // Compare on the falling edge, then advance the model across the next rising edge.
    initial begin
        forever begin
            int  efa, efb;
            bit  est;
            rec_t nr;
            @(negedge clk);
            efa = m_sel(0);
            efb = m_sel(1);
            est = m_stall();
            chk("model_fa_sel", int'(fa_sel), efa);
            chk("model_fb_sel", int'(fb_sel), efb);
            chk("model_stall", int'(load_use_stall), int'(est));
            chk("model_stall_cnt", int'(stall_cnt), m_stall_cnt);
            chk("model_fwd_cnt", int'(fwd_cnt), m_fwd_cnt);
            if (reset) begin
                hist.delete();
                m_stall_cnt = 0;
                m_fwd_cnt   = 0;
            end else if (!pipe_freeze) begin
                if (est && m_stall_cnt < CMAX) m_stall_cnt++;
                if (slot(0).v && (efa != 0 || efb != 0) && m_fwd_cnt < CMAX) m_fwd_cnt++;
                nr = '{v: id_valid, op: id_opcode, wb: id_wb_mux,
                       rd: id_rd, rs1: id_rs1, rs2: id_rs2};
                if (ex_flush || est) nr.v = 1'b0;
                hist.push_front(nr);
                if (hist.size() > DEPTH) void'(hist.pop_back());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input bit v, input logic [6:0] op, input write_back_mux_selector wb,
                       input int rd, input int rs1, input int rs2);
        id_valid  = v;
        id_opcode = op;
        id_wb_mux = wb;
        id_rd     = RW'(rd);
        id_rs1    = RW'(rs1);
        id_rs2    = RW'(rs2);
        #1;
    endtask

    task automatic nop();
        put(1'b0, OPCODE_OP, NO_WRITEBACK, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pipe_freeze = 1'b0; ex_flush = 1'b0;
        nop();
        tick(); tick();
        reset = 1'b0;
        chk("rst_fa", int'(fa_sel), 0);
        chk("rst_fb", int'(fb_sel), 0);
        chk("rst_stall", int'(load_use_stall), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_fwd_cnt", int'(fwd_cnt), 0);

        // Back-to-back dependency
        put(1'b1, OPCODE_OP, ALU_RESULT, 5, 1, 2); tick();
        put(1'b1, OPCODE_OP, ALU_RESULT, 6, 5, 5); tick();
        nop();
        chk("b2b_fa", int'(fa_sel), 1);
        chk("b2b_fb", int'(fb_sel), 1);
        tick();
        chk("b2b_fwd_cnt", int'(fwd_cnt), 1);

        // Two writers of x7: youngest wins
        put(1'b1, OPCODE_OPIMM, ALU_RESULT, 7, 0, 0); tick();
        put(1'b1, OPCODE_OPIMM, ALU_RESULT, 7, 0, 0); tick();
        put(1'b1, OPCODE_OP, ALU_RESULT, 8, 3, 7); tick();
        nop();
        chk("two_wr_fb", int'(fb_sel), 1);
        chk("two_wr_fa", int'(fa_sel), 0);
        tick();

        // Load-use
        put(1'b1, OPCODE_LOAD, MEM, 9, 1, 0); tick();
        put(1'b1, OPCODE_OPIMM, ALU_RESULT, 10, 9, 0);
        chk("lu_stall_on", int'(load_use_stall), 1);
        tick();
        chk("lu_stall_off", int'(load_use_stall), 0);
        tick();
        nop();
        chk("lu_fa", int'(fa_sel), 2);
        chk("lu_stall_cnt", int'(stall_cnt), 1);
        tick();

        // x0 destination and NO_WRITEBACK
        put(1'b1, OPCODE_OPIMM, ALU_RESULT, 0, 1, 0); tick();
        put(1'b1, OPCODE_STORE, NO_WRITEBACK, 4, 1, 2); tick();
        put(1'b1, OPCODE_OP, ALU_RESULT, 11, 0, 4); tick();
        nop();
        chk("x0_fa", int'(fa_sel), 0);
        chk("x0_fb", int'(fb_sel), 0);
        tick();

        // Freeze mid-dependency: selects and counters hold
        put(1'b1, OPCODE_OP, ALU_RESULT, 12, 1, 2); tick();
        put(1'b1, OPCODE_OP, ALU_RESULT, 13, 12, 12); tick();
        nop();
        pipe_freeze = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("frz_fa", int'(fa_sel), 1);
            chk("frz_fb", int'(fb_sel), 1);
            chk("frz_fwd_cnt", int'(fwd_cnt), 3);
            chk("frz_stall_cnt", int'(stall_cnt), 1);
            tick();
        end
        pipe_freeze = 1'b0;
        tick();
        chk("post_frz_fwd_cnt", int'(fwd_cnt), 4);

        // Flush gates a load-use pair
        put(1'b1, OPCODE_LOAD, MEM, 14, 1, 0); tick();
        put(1'b1, OPCODE_OPIMM, ALU_RESULT, 15, 14, 0);
        ex_flush = 1'b1;
        #1;
        chk("flush_stall", int'(load_use_stall), 0);
        tick();
        ex_flush = 1'b0;
        nop();
        chk("flush_fa", int'(fa_sel), 0);
        chk("flush_fb", int'(fb_sel), 0);
        chk("flush_stall_after", int'(load_use_stall), 0);
        chk("flush_stall_cnt", int'(stall_cnt), 1);
        tick();

        // Saturation: chained loads give a stall every other cycle (20 stalls)
        put(1'b1, OPCODE_LOAD, MEM, 16, 16, 0); tick();
        for (int i = 0; i < 40; i++) tick();
        chk("sat_stall_cnt", int'(stall_cnt), 15);

        // Reset during freeze wins
        reset = 1'b1; pipe_freeze = 1'b1;
        tick();
        reset = 1'b0; pipe_freeze = 1'b0;
        nop();
        chk("rst2_fa", int'(fa_sel), 0);
        chk("rst2_fb", int'(fb_sel), 0);
        chk("rst2_stall", int'(load_use_stall), 0);
        chk("rst2_stall_cnt", int'(stall_cnt), 0);
        chk("rst2_fwd_cnt", int'(fwd_cnt), 0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the RISC-V core, replacing fixed two-source EX/MEM/MEM-WB compare logic. It tracks up to DEPTH in-flight writeback records in an internal shift register, one per stage from EX onwards. It produces per-operand forwarding selects for the instruction in EX, a load-use stall request for the instruction in ID, and saturating performance counters. It sits between decode and the EX-stage operand muxes.

## Interface
- DEPTH, 3: tracked slots; slot 0 = EX, slot 1 = MEM, slot 2 = WB, and so on (min 2).
- REG_ADDR_W, 5: register index width.
- CNT_W, 32: performance counter width.
- FWD_W, $clog2(DEPTH): forwarding select width (derived, not overridable).
- clk  in  1  core clock. Only clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  7  ID opcode (CORE_PKG opcode constants).
- id_wb_mux  in  write_back_mux_selector  ID writeback kind.
- id_rd, id_rs1, id_rs2  in  REG_ADDR_W each  ID register indices.
- pipe_freeze  in  1  global pipeline hold (memory stall).
- ex_flush  in  1  kill the instruction entering EX.
- fa_sel, fb_sel  out  FWD_W each  operand A/B select for EX: 0 = register file, k = result held in slot k.
- load_use_stall  out  1  hold IF/ID; bubble enters EX.
- stall_cnt, fwd_cnt  out  CNT_W each  saturating counters.

## Operation
- Slot record: valid, opcode, wb_mux, rd, rs1, rs2. Slot 0 also carries the use mask for rs1/rs2.
- Use mask decoded from opcode:
  - OP, STORE, BRANCH: rs1 and rs2.
  - OPIMM, LOAD, JALR: rs1 only.
  - LUI, AUIPC, JAL, others: none.
- Writer condition for slot k: valid, wb_mux != NO_WRITEBACK, rd != 0.
- fa_sel is the lowest k in 1..DEPTH-1 where slot k is a writer, rd == slot0.rs1, slot 0 is valid, and slot 0 uses rs1. Otherwise 0. The youngest writer wins. fb_sel is the same for rs2.
- load_use_stall = id_valid && ID uses rsX && slot 0 is a writer with wb_mux = MEM && slot0.rd == id_rsX, for either source. It is forced to 0 while pipe_freeze or ex_flush is high.
- Per-edge update priority:
  1. reset: all slots invalid, counters 0.
  2. pipe_freeze: nothing changes, including counters. ex_flush is ignored; the pipeline re-presents it.
  3. Otherwise slots k ≥ 1 take slot k-1 and the oldest record drops. Slot 0 takes:
     - a bubble (valid = 0) if ex_flush or load_use_stall;
     - otherwise the ID record, with valid = id_valid.
- stall_cnt increments on each non-frozen cycle with load_use_stall = 1.
- fwd_cnt increments on each non-frozen cycle with slot 0 valid and fa_sel or fb_sel nonzero.
- Both counters saturate at all-ones.

## Timing
- Reset values: all slots invalid; fa_sel = fb_sel = 0; load_use_stall = 0; counters = 0.
- fa_sel, fb_sel, load_use_stall: combinational, same cycle as the inputs and slot state. No register on these outputs.
- An ID instruction appears in slot 0 one edge after capture. It reaches slot k after k+1 non-frozen edges.
- Load followed by a dependent instruction:
  - one stall cycle;
  - the dependent instruction then sees fa_sel/fb_sel = 2 (the load in MEM/WB) with DEPTH = 3.
- Simultaneous ex_flush and load_use_stall: the flush gates the stall; a single bubble enters.
- Reset during freeze: reset wins.
- Counters update one edge after their qualifying cycle.

## Structure
- CORE_PKG additions:
  - forward select encoding generalised to FWD_W bits; ORIGINAL_SELECT = 0, EX_RESULT_SELECT = 1, MEM_RESULT_SELECT = 2 kept for DEPTH = 3;
  - fwd_slot_t record struct;
  - use-mask decode function.
- Sub-module fwd_src_select: a parametrised priority match of one source index against slots 1..DEPTH-1. Instantiated twice (A, B).

## Test plan
- Back-to-back dependency:
  - stimulus: ADD x5 (OP, rd = 5), then ADD rs1 = 5, rs2 = 5;
  - required: fa_sel = fb_sel = 1 when the second is in EX; fwd_cnt = 1.
- Two writers:
  - stimulus: ADDI x7, then ADDI x7, then OR rs2 = 7;
  - required: fb_sel = 1 (youngest), not 2; fa_sel = 0 if rs1 = 3.
- Load-use:
  - stimulus: LW x9, then ADDI rs1 = 9;
  - required: load_use_stall = 1 for exactly one cycle, then fa_sel = 2; stall_cnt = 1.
- x0 and NO_WRITEBACK:
  - stimulus: ADDI x0, then SW with wb_mux = NO_WRITEBACK and rd field = 4, then OP rs1 = 0, rs2 = 4;
  - required: fa_sel = fb_sel = 0.
- Freeze and flush:
  - stimulus: pipe_freeze for 3 cycles mid-dependency;
  - required: selects held constant and counters unchanged during the freeze.
  - stimulus: then ex_flush with a load-use pair;
  - required: no stall, slot 0 invalid, selects 0.
- Saturation and reset:
  - stimulus: CNT_W = 4, 20 stalls;
  - required: stall_cnt = 15.
  - stimulus: then reset mid-stream;
  - required: every output 0 on the next cycle.
